axis_dwidth_downsizer: RTL and testbench

AXI4-Stream width downsizer: accepts wide beats on a slave port and emits them as a sequence of narrow beats on a master port, lowest-order sub-word first. It is the opposite-direction counterpart of the upsizing `axis_dwidth_converter_1` that packs narrow samples into wide words. It sits on the return path of the gaussian accelerator, splitting 64-bit result words back into 32-bit float samples for the 32-bit stream consumer.

---
 rtl/axis_dwidth_pkg.sv | 12 +
 rtl/axis_keep_last_idx.sv | 22 ++
 rtl/axis_dwidth_downsizer.sv | 111 +++++++++++
 tb/tb_axis_dwidth_downsizer.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_dwidth_pkg.sv
// Shared definitions for the AXI4-Stream width converters.
// Holds the converter state encodings and index-width helper.
package axis_dwidth_pkg;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  function automatic int idx_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/axis_keep_last_idx.sv
// Priority encoder: highest M-slice index of keep with any byte set.
// Ports: keep (S_DATA_WIDTH/8) in, idx (IW) out; 0 when keep is zero.
module axis_keep_last_idx #(
  parameter int S_DATA_WIDTH = 64,
  parameter int M_DATA_WIDTH = 32,
  parameter int IW           = 1
) (
  input  logic [S_DATA_WIDTH/8-1:0] keep,
  output logic [IW-1:0]             idx
);

  localparam int RATIO = S_DATA_WIDTH / M_DATA_WIDTH;
  localparam int MB    = M_DATA_WIDTH / 8;

  always_comb begin
    idx = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (|keep[k*MB +: MB]) idx = IW'(k);
    end
  end

endmodule

// File: rtl/axis_dwidth_downsizer.sv
// AXI4-Stream downsizer: splits wide beats into narrow beats, low word first.
// Ports: aclk, areset (sync, high), s_axis_* wide in, m_axis_* narrow out.
// AXIS_DWIDTH_DOWN_TKEEP_EN adds tkeep ports and trims zero-keep tail words.
module axis_dwidth_downsizer
  import axis_dwidth_pkg::*;
#(
  parameter int S_DATA_WIDTH = 64,
  parameter int M_DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tlast,
`ifdef AXIS_DWIDTH_DOWN_TKEEP_EN
  input  logic [S_DATA_WIDTH/8-1:0] s_axis_tkeep,
  output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
`endif
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast
);

  localparam int RATIO = S_DATA_WIDTH / M_DATA_WIDTH;
  localparam int IW    = idx_width(RATIO);

  logic [0:0]              state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [S_DATA_WIDTH-1:0] data_q, data_d;
  logic                    last_q, last_d;
  logic                    fin;
  logic                    s_hs;
  logic                    m_hs;

`ifdef AXIS_DWIDTH_DOWN_TKEEP_EN
  localparam int MB = M_DATA_WIDTH / 8;
  logic [S_DATA_WIDTH/8-1:0] keep_q, keep_d;
  logic [IW-1:0]             last_idx;

  axis_keep_last_idx #(
    .S_DATA_WIDTH (S_DATA_WIDTH),
    .M_DATA_WIDTH (M_DATA_WIDTH),
    .IW           (IW)
  ) u_last_idx (
    .keep (keep_q),
    .idx  (last_idx)
  );

  // On a last beat the packet ends at the top non-empty slice.
  assign fin = last_q ? (idx_q == last_idx)
                      : (idx_q == IW'(RATIO-1));
  assign m_axis_tkeep = keep_q[MB*int'(idx_q) +: MB];
`else
  assign fin = (idx_q == IW'(RATIO-1));
`endif

  assign m_axis_tvalid = !areset && (state_q == ST_DRAIN);
  // Refill in the same cycle the final sub-word leaves: no bubbles.
  assign s_axis_tready = !areset &&
                         ((state_q == ST_EMPTY) || (m_axis_tready && fin));
  assign m_axis_tdata  = data_q[M_DATA_WIDTH*int'(idx_q) +: M_DATA_WIDTH];
  assign m_axis_tlast  = last_q && fin;

  assign s_hs = s_axis_tvalid && s_axis_tready;
  assign m_hs = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef AXIS_DWIDTH_DOWN_TKEEP_EN
    keep_d  = keep_q;
`endif
    if (s_hs) begin
      state_d = ST_DRAIN;
      idx_d   = '0;
      data_d  = s_axis_tdata;
      last_d  = s_axis_tlast;
`ifdef AXIS_DWIDTH_DOWN_TKEEP_EN
      keep_d  = s_axis_tkeep;
`endif
    end else if (m_hs) begin
      if (fin) state_d = ST_EMPTY;
      else     idx_d   = IW'(idx_q + 1'b1);
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
`ifdef AXIS_DWIDTH_DOWN_TKEEP_EN
      keep_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
`ifdef AXIS_DWIDTH_DOWN_TKEEP_EN
      keep_q  <= keep_d;
`endif
    end
  end

endmodule

// File: tb/tb_axis_dwidth_downsizer.sv
// Directed bench for axis_dwidth_downsizer (64 -> 32).
// Covers reset, split, streaming, back-pressure, tkeep and mid-packet reset.
module tb_axis_dwidth_downsizer;

  logic        aclk;
  logic        areset;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] s_tdata;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
`ifdef AXIS_DWIDTH_DOWN_TKEEP_EN
  logic [7:0]  s_tkeep;
  logic [3:0]  m_tkeep;
`endif

  int checks = 0;
  int errors = 0;

  axis_dwidth_downsizer #(
    .S_DATA_WIDTH (64),
    .M_DATA_WIDTH (32)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
`ifdef AXIS_DWIDTH_DOWN_TKEEP_EN
    .s_axis_tkeep  (s_tkeep),
    .m_axis_tkeep  (m_tkeep),
`endif
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic test_reset;
    areset = 1'b1;
    repeat (3) begin
      @(negedge aclk); #1;
      checks++;
      if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got v=%b r=%b exp v=0 r=0",
                 m_tvalid, s_tready);
      end
    end
    @(negedge aclk);
    areset = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got v=%b r=%b exp v=0 r=1",
               m_tvalid, s_tready);
    end
  endtask

  task automatic test_basic_split;
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdata  = 64'h1111_2222_3333_4444;
    s_tlast  = 1'b1;
    m_tready = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b1) begin
      errors++;
      $display("FAIL split_accept got %b exp 1", s_tready);
    end
    @(negedge aclk);
    s_tvalid = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h3333_4444 || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL split_sub0 got v=%b d=%h l=%b exp v=1 d=33334444 l=0",
               m_tvalid, m_tdata, m_tlast);
    end
    checks++;
    if (s_tready !== 1'b0) begin
      errors++;
      $display("FAIL split_ready_sub0 got %b exp 0", s_tready);
    end
    @(negedge aclk); #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h1111_2222 || m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL split_sub1 got v=%b d=%h l=%b exp v=1 d=11112222 l=1",
               m_tvalid, m_tdata, m_tlast);
    end
    @(negedge aclk); #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL split_empty got %b exp 0", m_tvalid);
    end
  endtask

  task automatic test_streaming;
    int i     = 0;
    int got   = 0;
    int cyc   = 0;
    int first = -1;
    int lastc = -1;
    logic [31:0] ew;
    m_tready = 1'b1;
    while (got < 16 && cyc < 100) begin
      @(negedge aclk);
      s_tvalid = (i < 8);
      s_tdata  = {32'hC000_0000 | 32'(2*i+1), 32'hC000_0000 | 32'(2*i)};
      s_tlast  = (i == 7);
      #1;
      if (m_tvalid && m_tready) begin
        ew = 32'hC000_0000 | 32'(got);
        checks++;
        if (m_tdata !== ew || m_tlast !== (got == 15)) begin
          errors++;
          $display("FAIL stream_word%0d got d=%h l=%b exp d=%h l=%b",
                   got, m_tdata, m_tlast, ew, (got == 15));
        end
        if (first < 0) first = cyc;
        lastc = cyc;
        got++;
      end
      if (s_tvalid && s_tready) i++;
      cyc++;
    end
    s_tvalid = 1'b0;
    checks++;
    if (got != 16 || (lastc - first) != 15) begin
      errors++;
      $display("FAIL stream_span got n=%0d span=%0d exp n=16 span=15",
               got, lastc - first);
    end
    @(negedge aclk);
  endtask

  task automatic test_back_pressure;
    logic [33:0] q[$];
    logic [33:0] e;
    logic [33:0] prev_out;
    logic        prev_stall = 1'b0;
    logic        fin_now;
    logic        lst;
    int          i   = 0;
    int          got = 0;
    int          cyc = 0;
    while (got < 200 && cyc < 2000) begin
      @(negedge aclk);
      lst      = (i % 4 == 3);
      s_tvalid = (i < 100);
      s_tdata  = {32'hB000_0000 | 32'(2*i+1), 32'hB000_0000 | 32'(2*i)};
      s_tlast  = lst;
      m_tready = 1'($urandom_range(0, 1));
      #1;
      if (prev_stall) begin
        checks++;
        if ({m_tvalid, m_tlast, m_tdata} !== prev_out) begin
          errors++;
          $display("FAIL bp_stable got %h exp %h",
                   {m_tvalid, m_tlast, m_tdata}, prev_out);
        end
      end
      fin_now = (q.size() > 0) ? q[0][33] : 1'b0;
      if (m_tvalid && s_tready) begin
        checks++;
        if (!(m_tready && fin_now)) begin
          errors++;
          $display("FAIL bp_ready got r=%b exp r=0 (mr=%b fin=%b)",
                   s_tready, m_tready, fin_now);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra got d=%h exp none", m_tdata);
        end else begin
          e = q.pop_front();
          if ({m_tlast, m_tdata} !== e[32:0]) begin
            errors++;
            $display("FAIL bp_word%0d got %h exp %h",
                     got, {m_tlast, m_tdata}, e[32:0]);
          end
        end
        got++;
      end
      if (s_tvalid && s_tready) begin
        q.push_back({1'b0, 1'b0, s_tdata[31:0]});
        q.push_back({1'b1, lst, s_tdata[63:32]});
        i++;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tvalid, m_tlast, m_tdata};
      cyc++;
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    checks++;
    if (got != 200) begin
      errors++;
      $display("FAIL bp_count got %0d exp 200", got);
    end
    @(negedge aclk);
  endtask

`ifdef AXIS_DWIDTH_DOWN_TKEEP_EN
  task automatic test_tkeep;
    m_tready = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdata  = 64'hAAAA_BBBB_CCCC_DDDD;
    s_tlast  = 1'b1;
    s_tkeep  = 8'h0F;
    @(negedge aclk);
    s_tvalid = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'hCCCC_DDDD ||
        m_tkeep !== 4'hF || m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL keep0f got v=%b d=%h k=%h l=%b exp v=1 d=ccccdddd k=f l=1",
               m_tvalid, m_tdata, m_tkeep, m_tlast);
    end
    @(negedge aclk); #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL keep0f_drop got %b exp 0", m_tvalid);
    end
    s_tvalid = 1'b1;
    s_tdata  = 64'h0101_0202_0303_0404;
    s_tlast  = 1'b0;
    s_tkeep  = 8'hFF;
    @(negedge aclk);
    s_tvalid = 1'b0;
    #1;
    checks++;
    if (m_tdata !== 32'h0303_0404 || m_tkeep !== 4'hF || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL keepff_sub0 got d=%h k=%h l=%b exp d=03030404 k=f l=0",
               m_tdata, m_tkeep, m_tlast);
    end
    @(negedge aclk); #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h0101_0202 || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL keepff_sub1 got v=%b d=%h l=%b exp v=1 d=01010202 l=0",
               m_tvalid, m_tdata, m_tlast);
    end
    s_tvalid = 1'b1;
    s_tdata  = 64'h9999_8888_7777_6666;
    s_tlast  = 1'b1;
    s_tkeep  = 8'h00;
    @(negedge aclk);
    s_tvalid = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tkeep !== 4'h0 || m_tlast !== 1'b1) begin
      errors++;
      $display("FAIL keep00 got v=%b k=%h l=%b exp v=1 k=0 l=1",
               m_tvalid, m_tkeep, m_tlast);
    end
    @(negedge aclk); #1;
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL keep00_drop got %b exp 0", m_tvalid);
    end
    s_tkeep = 8'hFF;
  endtask
`endif

  task automatic test_mid_reset;
    m_tready = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdata  = 64'hDEAD_BEEF_0BAD_F00D;
    s_tlast  = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL mr_sub0 got v=%b d=%h exp v=1 d=0badf00d",
               m_tvalid, m_tdata);
    end
    @(negedge aclk);
    areset = 1'b1;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin
      errors++;
      $display("FAIL mr_in_reset got v=%b r=%b exp v=0 r=0",
               m_tvalid, s_tready);
    end
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || s_tready !== 1'b1) begin
      errors++;
      $display("FAIL mr_after got v=%b r=%b exp v=0 r=1",
               m_tvalid, s_tready);
    end
    s_tvalid = 1'b1;
    s_tdata  = 64'h5555_6666_7777_8888;
    s_tlast  = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b0;
    #1;
    checks++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'h7777_8888 || m_tlast !== 1'b0) begin
      errors++;
      $display("FAIL mr_next got v=%b d=%h l=%b exp v=1 d=77778888 l=0",
               m_tvalid, m_tdata, m_tlast);
    end
    @(negedge aclk);
    @(negedge aclk);
  endtask

  initial begin
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
`ifdef AXIS_DWIDTH_DOWN_TKEEP_EN
    s_tkeep  = 8'hFF;
`endif
    test_reset();
    test_basic_split();
    test_streaming();
    test_back_pressure();
`ifdef AXIS_DWIDTH_DOWN_TKEEP_EN
    test_tkeep();
`endif
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
